// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo PWM constants, FSM states and width classifier
package servo_pkg;

   localparam int unsigned CNT_W     = 21;
   localparam int unsigned FRAME_CNT = 1_000_000;
   localparam int unsigned PER_TOL   = 100_000;
   localparam int unsigned MIN_W     = 40_000;
   localparam int unsigned MAX_W     = 300_000;
   localparam int unsigned LOST_CNT  = 1_250_000;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam int unsigned NOM_W [7] = '{80_000, 119_000, 150_000, 182_000,
                                         216_000, 248_000, 275_000};
   localparam int unsigned CODE_TH [6] = '{99_500, 134_500, 166_000,
                                           199_000, 232_000, 261_500};

   typedef enum logic [1:0] {
      WAIT_LOW,
      IDLE,
      HIGH,
      LOW
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Code 0 is never produced; anything below the first threshold is code 1.
   function automatic logic [2:0] width_to_code(input logic [CNT_W-1:0] w,
                                                input int unsigned scale);
      logic [2:0] code;
      code = 3'd1;
      for (int i = 0; i < 6; i++) begin
         if (w >= CNT_W'(CODE_TH[i] / scale)) code = 3'(i + 2);
      end
      return code;
   endfunction

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// rtl/servo_pwm_decoder_if.sv - PWM input line and decoded result bundle
interface servo_pwm_decoder_if;
   import servo_pkg::*;

   logic             pwm_in;
   logic [2:0]       ctr_out;
   logic [CNT_W-1:0] width_out;
   logic             valid;
   logic             width_err;
   logic             period_err;
   logic             lost;

   modport master (
      input  pwm_in,
      output ctr_out, width_out, valid, width_err, period_err, lost
   );

   modport slave (
      output pwm_in,
      input  ctr_out, width_out, valid, width_err, period_err, lost
   );

endinterface

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - two-flop synchronizer with registered-copy edge detect
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - measures servo PWM width/period and decodes position code
// TIME_SCALE divides every cycle-count constant; 1 for the 50 MHz build.
module servo_pwm_decoder
   import servo_pkg::*;
#(
   parameter int unsigned TIME_SCALE = 1
) (
   input  logic                clk,
   input  logic                rst,
   servo_pwm_decoder_if.master bus
);

   localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(MIN_W / TIME_SCALE);
   localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(MAX_W / TIME_SCALE);
   localparam logic [CNT_W-1:0] P_PER_LO = CNT_W'((FRAME_CNT - PER_TOL) / TIME_SCALE);
   localparam logic [CNT_W-1:0] P_PER_HI = CNT_W'((FRAME_CNT + PER_TOL) / TIME_SCALE);
   localparam logic [CNT_W-1:0] P_LOST   = CNT_W'(LOST_CNT / TIME_SCALE);

   logic pwm_s, rise, fall;

   pwm_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.pwm_in),
      .level_o (pwm_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
   logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
   logic [2:0]       ctr_q, ctr_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             valid_q, valid_d;
   logic             werr_q, werr_d;
   logic             perr_q, perr_d;
   logic             lost_q, lost_d;
   logic [1:0]       settle_q, settle_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= WAIT_LOW;
         w_cnt_q  <= '0;
         p_cnt_q  <= '0;
         ctr_q    <= '0;
         width_q  <= '0;
         valid_q  <= 1'b0;
         werr_q   <= 1'b0;
         perr_q   <= 1'b0;
         lost_q   <= 1'b0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         w_cnt_q  <= w_cnt_d;
         p_cnt_q  <= p_cnt_d;
         ctr_q    <= ctr_d;
         width_q  <= width_d;
         valid_q  <= valid_d;
         werr_q   <= werr_d;
         perr_q   <= perr_d;
         lost_q   <= lost_d;
         settle_q <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      w_cnt_d  = w_cnt_q;
      p_cnt_d  = p_cnt_q;
      ctr_d    = ctr_q;
      width_d  = width_q;
      valid_d  = 1'b0;
      werr_d   = 1'b0;
      perr_d   = perr_q;
      lost_d   = lost_q;
      settle_d = settle_q[1] ? settle_q : settle_q + 2'd1;

      case (state_q)
         // The synchronizer also restarts at 0, so pwm_s is only trusted once it has refilled.
         WAIT_LOW: if (settle_q[1] && !pwm_s) state_d = IDLE;
         IDLE: begin
            if (rise) begin
               state_d = HIGH;
               w_cnt_d = 21'd1;
               p_cnt_d = 21'd1;
               lost_d  = 1'b0;
            end
         end
         HIGH: begin
            w_cnt_d = sat_inc(w_cnt_q);
            p_cnt_d = sat_inc(p_cnt_q);
            if (fall) begin
               state_d = LOW;
               if (w_cnt_q >= P_MIN && w_cnt_q <= P_MAX) begin
                  ctr_d   = width_to_code(w_cnt_q, TIME_SCALE);
                  width_d = w_cnt_q;
                  valid_d = 1'b1;
               end else begin
                  werr_d = 1'b1;
               end
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
               perr_d  = (p_cnt_q < P_PER_LO) || (p_cnt_q > P_PER_HI);
               w_cnt_d = 21'd1;
               p_cnt_d = 21'd1;
            end else begin
               p_cnt_d = sat_inc(p_cnt_q);
            end
         end
         default: state_d = WAIT_LOW;
      endcase

      // A rise in the same cycle restarts p_cnt at 1, so it always wins over loss.
      if ((state_q == HIGH || state_q == LOW) && p_cnt_d == P_LOST) begin
         lost_d  = 1'b1;
         state_d = pwm_s ? WAIT_LOW : IDLE;
         w_cnt_d = '0;
         p_cnt_d = '0;
      end
   end

   assign bus.ctr_out    = ctr_q;
   assign bus.width_out  = width_q;
   assign bus.valid      = valid_q;
   assign bus.width_err  = werr_q;
   assign bus.period_err = perr_q;
   assign bus.lost       = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder at 1/500 time scale
module tb_servo_pwm_decoder;
   import servo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   servo_pwm_decoder_if bus ();

   servo_pwm_decoder #(.TIME_SCALE(500)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  code;
      logic [20:0] width;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;

   logic [2:0]  m_code  = 3'd0;
   logic [20:0] m_width = 21'd0;
   logic        m_perr  = 1'b0;
   int          prev_period = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] model_code(input int w);
      int th [6] = '{199, 269, 332, 398, 464, 523};
      logic [2:0] c;
      c = 3'd1;
      for (int i = 0; i < 6; i++) if (w >= th[i]) c = 3'(i + 2);
      return c;
   endfunction

   task automatic send(input int high, input int period);
      exp_t e;
      if (high >= 80 && high <= 600) begin
         m_code  = model_code(high);
         m_width = 21'(high);
         e.kind  = 2'b10;
      end else begin
         e.kind  = 2'b01;
      end
      e.code  = m_code;
      e.width = m_width;
      sb.push_back(e);
      if (prev_period != 0) m_perr = (prev_period < 1800) || (prev_period > 2200);
      bus.pwm_in = 1'b1;
      repeat (high) step();
      check("period_err", 32'(bus.period_err), 32'(m_perr));
      check("lost_after_rise", 32'(bus.lost), 32'd0);
      bus.pwm_in = 1'b0;
      repeat (period - high) step();
      prev_period = period;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_ctr"},   32'(bus.ctr_out),    32'd0);
      check({tag, "_width"}, 32'(bus.width_out),  32'd0);
      check({tag, "_valid"}, 32'(bus.valid),      32'd0);
      check({tag, "_werr"},  32'(bus.width_err),  32'd0);
      check({tag, "_perr"},  32'(bus.period_err), 32'd0);
      check({tag, "_lost"},  32'(bus.lost),       32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.valid || bus.width_err)) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'({bus.valid, bus.width_err}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("out_kind",  32'({bus.valid, bus.width_err}), 32'(mon_e.kind));
            check("out_ctr",   32'(bus.ctr_out),   32'(mon_e.code));
            check("out_width", 32'(bus.width_out), 32'(mon_e.width));
         end
      end
   end

   initial begin
      int sweep [8] = '{160, 238, 364, 432, 496, 550, 198, 199};

      // Reset asserted while the line is already mid-pulse.
      bus.pwm_in = 1'b1;
      #2 rst = 1'b1;
      repeat (3) step();
      check_cleared("reset");
      rst = 1'b0;
      repeat (200) step();
      bus.pwm_in = 1'b0;
      repeat (1800) step();
      check("partial_discarded", 32'(sb.size()), 32'd0);

      for (int i = 0; i < 5; i++) send(300, 2000);
      check("nominal_drained", 32'(sb.size()), 32'd0);

      foreach (sweep[i]) send(sweep[i], 2000);
      check("sweep_drained", 32'(sb.size()), 32'd0);

      send(60, 2000);
      send(700, 2000);
      check("werr_drained", 32'(sb.size()), 32'd0);

      send(300, 1700);
      send(300, 2000);
      send(300, 2000);

      // Line stays low: loss is due 2499 edges after the last rise was seen.
      repeat (501) step();
      check("lost_before_limit", 32'(bus.lost), 32'd0);
      step();
      check("lost_low", 32'(bus.lost), 32'd1);
      prev_period = 0;
      repeat (100) step();
      send(300, 2000);

      // Line stuck high after a normal rise.
      m_perr = 1'b0;
      bus.pwm_in = 1'b1;
      for (int i = 0; i < 2600 && !bus.lost; i++) step();
      check("lost_high", 32'(bus.lost), 32'd1);
      step();
      check("lost_high_state", 32'(dut.state_q), 32'(WAIT_LOW));
      check("lost_high_perr", 32'(bus.period_err), 32'd0);
      bus.pwm_in = 1'b0;
      prev_period = 0;
      repeat (200) step();
      send(300, 2000);
      check("lost_drained", 32'(sb.size()), 32'd0);

      // Reset pulsed partway through a pulse of 700 counted cycles.
      bus.pwm_in = 1'b1;
      repeat (703) step();
      #2 rst = 1'b1;
      #1 check_cleared("midrst");
      step();
      rst = 1'b0;
      m_code = 3'd0;
      m_width = 21'd0;
      m_perr = 1'b0;
      prev_period = 0;
      repeat (100) step();
      bus.pwm_in = 1'b0;
      repeat (1200) step();
      check("midrst_no_valid", 32'(sb.size()), 32'd0);
      check("midrst_ctr_hold", 32'(bus.ctr_out), 32'd0);
      send(364, 2000);
      check("final_drained", 32'(sb.size()), 32'd0);
      check("final_ctr", 32'(bus.ctr_out), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
